// File: rtl/lcd_responder.sv
// Bus-level model of an HD44780-style character LCD: 80-byte DDRAM, address counter,
// busy-flag timing and BF/AC/DDRAM reads, driven from a synchronised e/rs/rw/data bus.
module lcd_responder #(
    parameter int unsigned CYCLES_CLR   = 76500,
    parameter int unsigned CYCLES_HOME  = 76500,
    parameter int unsigned CYCLES_CMD   = 1950,
    parameter int unsigned CYCLES_DATA  = 2150,
    parameter int unsigned CYCLES_E_MIN = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       busy,
    output logic [6:0] addr_counter,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       incr_mode,
    output logic       access_err,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_char
);

    localparam int unsigned DEPTH   = 80;
    localparam int unsigned MAX_A   = (CYCLES_CLR > CYCLES_HOME) ? CYCLES_CLR : CYCLES_HOME;
    localparam int unsigned MAX_B   = (CYCLES_CMD > CYCLES_DATA) ? CYCLES_CMD : CYCLES_DATA;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    localparam int unsigned WW      = $clog2(CYCLES_E_MIN + 1);
    localparam logic [7:0]  BLANK   = 8'h20;

    localparam logic [1:0] ST_INIT_FILL = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_E_HIGH    = 2'd2;
    localparam logic [1:0] ST_EXEC      = 2'd3;

    function automatic logic addr_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    function automatic logic [6:0] addr_idx(input logic [6:0] a);
        return (a < 7'h40) ? a : a - 7'd24;
    endfunction

    // Line 1 and line 2 form one 80-entry ring in address order.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27)      return 7'h40;
            else if (a == 7'h67) return 7'h00;
            else                 return a + 7'd1;
        end else begin
            if (a == 7'h00)      return 7'h67;
            else if (a == 7'h40) return 7'h27;
            else                 return a - 7'd1;
        end
    endfunction

    logic       e_s1_q, e_s2_q, e_s3_q;
    logic       rs_s1_q, rs_s2_q, rw_s1_q, rw_s2_q;
    logic [7:0] d_s1_q, d_s2_q;

    logic [1:0]    state_q, state_d;
    logic [WW-1:0] width_q, width_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fill_active_q, fill_active_d;
    logic [6:0]    fill_idx_q, fill_idx_d;
    logic          rd_q, rd_d, rsel_q, rsel_d;
    logic [6:0]    ac_q, ac_d;
    logic          incr_q, incr_d, disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          data_oe_q, data_oe_d, busy_q, busy_d, err_q, err_d;
    logic [7:0]    dbg_char_q, dbg_char_d;
    logic [7:0]    mem_q [0:DEPTH-1];

    logic          mem_we;
    logic [6:0]    mem_waddr;
    logic [7:0]    mem_wdata;
    logic          load_en, exit_access;
    logic [CW-1:0] load_val;
    logic          e_rise, e_fall;
    logic [6:0]    ac_idx;

    assign e_rise = e_s2_q & ~e_s3_q;
    assign e_fall = ~e_s2_q & e_s3_q;
    assign ac_idx = addr_idx(ac_q);

    always_comb begin
        state_d       = state_q;
        width_d       = width_q;
        cnt_d         = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        fill_active_d = fill_active_q;
        fill_idx_d    = fill_idx_q;
        rd_d          = rd_q;
        rsel_d        = rsel_q;
        ac_d          = ac_q;
        incr_d        = incr_q;
        disp_d        = disp_q;
        cur_d         = cur_q;
        blink_d       = blink_q;
        data_out_d    = data_out_q;
        data_oe_d     = 1'b0;
        err_d         = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = fill_idx_q;
        mem_wdata     = BLANK;
        load_en       = 1'b0;
        load_val      = '0;
        exit_access   = 1'b0;

        // Blank-fill engine shared by power-up init and the clear command.
        if (fill_active_q) begin
            mem_we = 1'b1;
            if (fill_idx_q == 7'(DEPTH - 1)) fill_active_d = 1'b0;
            else                             fill_idx_d    = fill_idx_q + 7'd1;
        end

        case (state_q)
            ST_INIT_FILL: begin
                if (e_fall && !rw_s2_q) err_d = 1'b1;
                if (!fill_active_d)     state_d = ST_IDLE;
            end
            ST_IDLE, ST_EXEC: begin
                if (state_q == ST_EXEC && cnt_d == '0) state_d = ST_IDLE;
                if (e_rise) begin
                    state_d   = ST_E_HIGH;
                    width_d   = WW'(1);
                    rd_d      = rw_s2_q;
                    rsel_d    = rs_s2_q;
                    data_oe_d = rw_s2_q;
                end
            end
            default: begin
                data_oe_d = rd_q;
                if (e_s2_q) begin
                    if (width_q < WW'(CYCLES_E_MIN)) width_d = width_q + WW'(1);
                end else begin
                    exit_access = 1'b1;
                    if (width_q < WW'(CYCLES_E_MIN)) begin
                        err_d = 1'b1;
                    end else if (busy_q) begin
                        // Only BF/AC reads are honoured while busy.
                        if (!(rw_s2_q && !rs_s2_q)) err_d = 1'b1;
                    end else if (!rs_s2_q && !rw_s2_q) begin
                        if (d_s2_q[7]) begin
                            load_en = 1'b1; load_val = CW'(CYCLES_CMD);
                            if (addr_valid(d_s2_q[6:0])) ac_d  = d_s2_q[6:0];
                            else                         err_d = 1'b1;
                        end else if (d_s2_q[6] || d_s2_q[5]) begin
                            load_en = 1'b1; load_val = CW'(CYCLES_CMD);
                        end else if (d_s2_q[4]) begin
                            load_en = 1'b1; load_val = CW'(CYCLES_CMD);
                            if (!d_s2_q[3]) ac_d = ac_step(ac_q, d_s2_q[2]);
                        end else if (d_s2_q[3]) begin
                            load_en = 1'b1; load_val = CW'(CYCLES_CMD);
                            disp_d  = d_s2_q[2];
                            cur_d   = d_s2_q[1];
                            blink_d = d_s2_q[0];
                        end else if (d_s2_q[2]) begin
                            load_en = 1'b1; load_val = CW'(CYCLES_CMD);
                            incr_d  = d_s2_q[1];
                        end else if (d_s2_q[1]) begin
                            load_en = 1'b1; load_val = CW'(CYCLES_HOME);
                            ac_d    = 7'h00;
                        end else if (d_s2_q[0]) begin
                            load_en       = 1'b1; load_val = CW'(CYCLES_CLR);
                            ac_d          = 7'h00;
                            incr_d        = 1'b1;
                            fill_active_d = 1'b1;
                            fill_idx_d    = 7'd0;
                        end
                    end else if (rs_s2_q && !rw_s2_q) begin
                        mem_we    = 1'b1;
                        mem_waddr = ac_idx;
                        mem_wdata = d_s2_q;
                        ac_d      = ac_step(ac_q, incr_q);
                        load_en   = 1'b1; load_val = CW'(CYCLES_DATA);
                    end else if (rs_s2_q && rw_s2_q) begin
                        ac_d    = ac_step(ac_q, incr_q);
                        load_en = 1'b1; load_val = CW'(CYCLES_DATA);
                    end
                end
            end
        endcase

        if (load_en)     cnt_d   = load_val;
        if (exit_access) state_d = (cnt_d != '0) ? ST_EXEC : ST_IDLE;
        busy_d = fill_active_d || (cnt_d != '0);

        if (data_oe_d) data_out_d = rsel_d ? mem_q[ac_idx] : {busy_q, ac_q};
        dbg_char_d = addr_valid(dbg_addr) ? mem_q[addr_idx(dbg_addr)] : BLANK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_s1_q        <= 1'b0;
            e_s2_q        <= 1'b0;
            e_s3_q        <= 1'b0;
            rs_s1_q       <= 1'b0;
            rs_s2_q       <= 1'b0;
            rw_s1_q       <= 1'b0;
            rw_s2_q       <= 1'b0;
            d_s1_q        <= 8'h00;
            d_s2_q        <= 8'h00;
            state_q       <= ST_INIT_FILL;
            width_q       <= '0;
            cnt_q         <= '0;
            fill_active_q <= 1'b1;
            fill_idx_q    <= 7'd0;
            rd_q          <= 1'b0;
            rsel_q        <= 1'b0;
            ac_q          <= 7'h00;
            incr_q        <= 1'b1;
            disp_q        <= 1'b0;
            cur_q         <= 1'b0;
            blink_q       <= 1'b0;
            data_out_q    <= 8'h00;
            data_oe_q     <= 1'b0;
            busy_q        <= 1'b1;
            err_q         <= 1'b0;
            dbg_char_q    <= BLANK;
        end else begin
            e_s1_q        <= e;
            e_s2_q        <= e_s1_q;
            e_s3_q        <= e_s2_q;
            rs_s1_q       <= rs;
            rs_s2_q       <= rs_s1_q;
            rw_s1_q       <= rw;
            rw_s2_q       <= rw_s1_q;
            d_s1_q        <= data_in;
            d_s2_q        <= d_s1_q;
            state_q       <= state_d;
            width_q       <= width_d;
            cnt_q         <= cnt_d;
            fill_active_q <= fill_active_d;
            fill_idx_q    <= fill_idx_d;
            rd_q          <= rd_d;
            rsel_q        <= rsel_d;
            ac_q          <= ac_d;
            incr_q        <= incr_d;
            disp_q        <= disp_d;
            cur_q         <= cur_d;
            blink_q       <= blink_d;
            data_out_q    <= data_out_d;
            data_oe_q     <= data_oe_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            dbg_char_q    <= dbg_char_d;
        end
    end

    // DDRAM contents are established by the init fill, so the array itself has no reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign data_out     = data_out_q;
    assign data_oe      = data_oe_q;
    assign busy         = busy_q;
    assign addr_counter = ac_q;
    assign display_on   = disp_q;
    assign cursor_on    = cur_q;
    assign blink_on     = blink_q;
    assign incr_mode    = incr_q;
    assign access_err   = err_q;
    assign dbg_char     = dbg_char_q;

endmodule
